// File: rtl/sl811_port_responder_pkg.sv
// Shared types and default register map for the SL811 host-port responder.
package sl811_port_responder_pkg;

  typedef logic [7:0] Byte_t;
  typedef logic       Bit_t;

  localparam Byte_t DefAutoincBase  = 8'h10;
  localparam Byte_t DefIntEnAddr    = 8'h06;
  localparam Byte_t DefIntStatAddr  = 8'h0D;

  // Post-increment applies only in the auto-increment window; 8'hFF wraps to 8'h00.
  function automatic Byte_t ptr_advance(Byte_t ptr, Byte_t base);
    return (ptr >= base) ? Byte_t'(ptr + 8'd1) : ptr;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable width and reset value.
module sync_2ff #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, meta_d;
  logic [Width-1:0] sync_q, sync_d;

  // Next state: shift the raw input through two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sl811_port_responder.sv
// SL811-style host port: address pointer, 256x8 register file, interrupt
// enable/status with write-1-to-clear, and a local notify/read port.
module sl811_port_responder
  import sl811_port_responder_pkg::*;
#(
  parameter Byte_t AUTOINC_BASE  = DefAutoincBase,
  parameter Byte_t INT_EN_ADDR   = DefIntEnAddr,
  parameter Byte_t INT_STAT_ADDR = DefIntStatAddr
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sl811_a0,
  inout  wire  [7:0] sl811_d,
  input  logic       sl811_cs_n,
  input  logic       sl811_rd_n,
  input  logic       sl811_wr_n,
  input  logic       sl811_dack_n,
  output logic       sl811_intrq,
  output logic       sl811_drq_n,
  input  logic [7:0] dev_set_irq,
  output logic       dev_wr_valid,
  output logic [7:0] dev_wr_addr,
  output logic [7:0] dev_wr_data,
  input  logic [7:0] dev_rd_addr,
  output logic [7:0] dev_rd_data
);

  // DMA is not supported.
  Bit_t unused_dack;
  assign unused_dack = sl811_dack_n;
  assign sl811_drq_n = 1'b1;

  // Synchronized host signals.
  logic [2:0] strb_s;
  logic [8:0] data_s;

  sync_2ff #(
    .Width    (3),
    .ResetVal (3'b111)
  ) u_sync_strb (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({sl811_cs_n, sl811_rd_n, sl811_wr_n}),
    .q_o   (strb_s)
  );

  sync_2ff #(
    .Width    (9),
    .ResetVal (9'h000)
  ) u_sync_data (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({sl811_a0, sl811_d}),
    .q_o   (data_s)
  );

  Bit_t  cs_n_s, rd_n_s, wr_n_s, a0_s;
  Byte_t d_s;
  Bit_t  rd_act, wr_act;

  assign cs_n_s = strb_s[2];
  assign rd_n_s = strb_s[1];
  assign wr_n_s = strb_s[0];
  assign a0_s   = data_s[8];
  assign d_s    = data_s[7:0];

  // Both strobes low is illegal and decodes to neither access.
  assign rd_act = ~cs_n_s & ~rd_n_s &  wr_n_s;
  assign wr_act = ~cs_n_s & ~wr_n_s &  rd_n_s;

  // State.
  Bit_t  rd_act_q, rd_act_d;
  Bit_t  wr_act_q, wr_act_d;
  Bit_t  rd_a0_q, rd_a0_d;
  Bit_t  wr_a0_q, wr_a0_d;
  Byte_t wr_data_q, wr_data_d;
  Byte_t ptr_q, ptr_d;
  Byte_t stat_q, stat_d;
  Byte_t en_q, en_d;
  Bit_t  intrq_q, intrq_d;
  Byte_t rd_latch_q, rd_latch_d;
  Bit_t  wr_valid_q, wr_valid_d;
  Byte_t wr_addr_q, wr_addr_d;
  Byte_t wr_dout_q, wr_dout_d;
  Byte_t dev_rd_q, dev_rd_d;

  Byte_t mem_q [256];
  Bit_t  mem_we;
  Byte_t w1c;
  Byte_t ptr_rd_val, dev_rd_val;

  // Register-file read muxes for the host pointer and the local read port.
  always_comb begin
    ptr_rd_val = mem_q[ptr_q];
    if (ptr_q == INT_EN_ADDR) begin
      ptr_rd_val = en_q;
    end else if (ptr_q == INT_STAT_ADDR) begin
      ptr_rd_val = stat_q;
    end
    dev_rd_val = mem_q[dev_rd_addr];
    if (dev_rd_addr == INT_EN_ADDR) begin
      dev_rd_val = en_q;
    end else if (dev_rd_addr == INT_STAT_ADDR) begin
      dev_rd_val = stat_q;
    end
  end

  // Access decode, commit, pointer update and interrupt next-state.
  always_comb begin
    rd_act_d   = rd_act;
    wr_act_d   = wr_act;
    rd_a0_d    = rd_a0_q;
    wr_a0_d    = wr_a0_q;
    wr_data_d  = wr_data_q;
    ptr_d      = ptr_q;
    en_d       = en_q;
    rd_latch_d = rd_latch_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dout_d  = wr_dout_q;
    mem_we     = 1'b0;
    w1c        = 8'h00;

    // Track bus data while the write strobe is active; the last sample is committed.
    if (wr_act) begin
      wr_data_d = d_s;
      wr_a0_d   = a0_s;
    end

    if (rd_act && !rd_act_q) begin
      rd_latch_d = a0_s ? ptr_rd_val : ptr_q;
      rd_a0_d    = a0_s;
    end

    if (!rd_act && rd_act_q && rd_a0_q) begin
      ptr_d = ptr_advance(ptr_q, AUTOINC_BASE);
    end

    // Commit only when wr_n itself released; a drop caused by rd_n or cs_n aborts.
    if (!wr_act && wr_act_q && wr_n_s) begin
      if (!wr_a0_q) begin
        ptr_d = wr_data_q;
      end else begin
        wr_valid_d = 1'b1;
        wr_addr_d  = ptr_q;
        wr_dout_d  = wr_data_q;
        ptr_d      = ptr_advance(ptr_q, AUTOINC_BASE);
        if (ptr_q == INT_EN_ADDR) begin
          en_d = wr_data_q;
        end else if (ptr_q == INT_STAT_ADDR) begin
          w1c = wr_data_q;
        end else begin
          mem_we = 1'b1;
        end
      end
    end

    // Set wins over clear.
    stat_d   = (stat_q & ~w1c) | dev_set_irq;
    intrq_d  = |(stat_q & en_q);
    dev_rd_d = dev_rd_val;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_act_q   <= 1'b0;
      wr_act_q   <= 1'b0;
      rd_a0_q    <= 1'b0;
      wr_a0_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      ptr_q      <= 8'h00;
      stat_q     <= 8'h00;
      en_q       <= 8'h00;
      intrq_q    <= 1'b0;
      rd_latch_q <= 8'h00;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_dout_q  <= 8'h00;
      dev_rd_q   <= 8'h00;
    end else begin
      rd_act_q   <= rd_act_d;
      wr_act_q   <= wr_act_d;
      rd_a0_q    <= rd_a0_d;
      wr_a0_q    <= wr_a0_d;
      wr_data_q  <= wr_data_d;
      ptr_q      <= ptr_d;
      stat_q     <= stat_d;
      en_q       <= en_d;
      intrq_q    <= intrq_d;
      rd_latch_q <= rd_latch_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_dout_q  <= wr_dout_d;
      dev_rd_q   <= dev_rd_d;
    end
  end

  // Register file storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= wr_data_q;
    end
  end

  // Drive enable follows rd_act by one cycle so the latch is loaded before driving.
  assign sl811_d      = rd_act_q ? rd_latch_q : 8'bzzzz_zzzz;
  assign sl811_intrq  = intrq_q;
  assign dev_wr_valid = wr_valid_q;
  assign dev_wr_addr  = wr_addr_q;
  assign dev_wr_data  = wr_dout_q;
  assign dev_rd_data  = dev_rd_q;

endmodule

// File: tb/tb_sl811_port_responder.sv
// Directed bench with a scoreboard for write notifications.
module tb_sl811_port_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a0, cs_n, rd_n, wr_n, dack_n;
  logic [7:0] host_d;
  logic       host_oe;
  wire  [7:0] bus;
  logic       intrq, drq_n;
  logic [7:0] set_irq, rd_addr, rd_data, wr_addr, wr_data;
  logic       wr_valid;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  assign bus = host_oe ? host_d : 8'bzzzz_zzzz;
  pullup (bus);

  always #5 clk = ~clk;

  sl811_port_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sl811_a0     (a0),
    .sl811_d      (bus),
    .sl811_cs_n   (cs_n),
    .sl811_rd_n   (rd_n),
    .sl811_wr_n   (wr_n),
    .sl811_dack_n (dack_n),
    .sl811_intrq  (intrq),
    .sl811_drq_n  (drq_n),
    .dev_set_irq  (set_irq),
    .dev_wr_valid (wr_valid),
    .dev_wr_addr  (wr_addr),
    .dev_wr_data  (wr_data),
    .dev_rd_addr  (rd_addr),
    .dev_rd_data  (rd_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write notification must match the oldest expected entry.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_notify: got addr %h data %h expected no notification", wr_addr, wr_data);
      end else begin
        check("wr_notify", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic host_write(input logic a, input logic [7:0] d, input logic [7:0] irq);
    @(posedge clk); #1;
    a0 = a; host_d = d; host_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1; cs_n = 1'b1; wr_n = 1'b1;
    // Commit lands on the third edge after release; align irq with it.
    repeat (2) @(posedge clk);
    #1; set_irq = irq;
    @(posedge clk); #1; set_irq = 8'h00;
    repeat (2) @(posedge clk);
    #1; host_oe = 1'b0;
  endtask

  task automatic host_read(input logic a, output logic [7:0] d);
    @(posedge clk); #1;
    a0 = a; host_oe = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); d = bus;
    @(posedge clk); #1; cs_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); check("bus_release", 16'(bus), 16'h00FF);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    host_write(1'b0, p, 8'h00);
  endtask

  task automatic expect_ptr(input string name, input logic [7:0] p);
    logic [7:0] v;
    host_read(1'b0, v);
    check(name, 16'(v), 16'(p));
  endtask

  task automatic peek(input string name, input logic [7:0] addr, input logic [7:0] exp);
    @(posedge clk); #1; rd_addr = addr;
    @(posedge clk); @(negedge clk);
    check(name, 16'(rd_data), 16'(exp));
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    @(posedge clk); #1; set_irq = v;
    @(posedge clk); @(negedge clk);
    set_irq = 8'h00;
    check("intrq_lag", 16'(intrq), 16'h0000);
    @(posedge clk); @(negedge clk);
    check("intrq_set", 16'(intrq), 16'h0001);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1; a0 = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; dack_n = 1'b1;
    host_d = 8'h00; host_oe = 1'b0; set_irq = 8'h00; rd_addr = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_intrq", 16'(intrq), 16'h0000);
    check("rst_wr_valid", 16'(wr_valid), 16'h0000);
    check("rst_rd_data", 16'(rd_data), 16'h0000);
    check("rst_bus", 16'(bus), 16'h00FF);
    check("drq_n", 16'(drq_n), 16'h0001);
    @(posedge clk); #1; rst = 1'b0;
    expect_ptr("ptr_after_rst", 8'h00);

    // Pointer then data write with auto-increment.
    set_ptr(8'h20);
    exp_q.push_back({8'h20, 8'hA5});
    host_write(1'b1, 8'hA5, 8'h00);
    expect_ptr("ptr_autoinc_wr", 8'h21);
    peek("reg20", 8'h20, 8'hA5);

    // Data read with auto-increment.
    set_ptr(8'h20);
    host_read(1'b1, v);
    check("data_read", 16'(v), 16'h00A5);
    expect_ptr("ptr_autoinc_rd", 8'h21);

    // Interrupt enable, set, W1C, and set-wins-over-clear.
    set_ptr(8'h06);
    exp_q.push_back({8'h06, 8'h01});
    host_write(1'b1, 8'h01, 8'h00);
    expect_ptr("ptr_no_inc", 8'h06);
    peek("en_reg", 8'h06, 8'h01);
    pulse_irq(8'h01);
    set_ptr(8'h0D);
    exp_q.push_back({8'h0D, 8'h01});
    host_write(1'b1, 8'h01, 8'h00);
    @(negedge clk); check("intrq_w1c", 16'(intrq), 16'h0000);
    peek("stat_cleared", 8'h0D, 8'h00);
    pulse_irq(8'h01);
    exp_q.push_back({8'h0D, 8'h01});
    host_write(1'b1, 8'h01, 8'h01);
    @(negedge clk); check("intrq_set_wins", 16'(intrq), 16'h0001);
    peek("stat_set_wins", 8'h0D, 8'h01);

    // Pointer wrap and no-increment below the window.
    set_ptr(8'hFF);
    exp_q.push_back({8'hFF, 8'h11});
    host_write(1'b1, 8'h11, 8'h00);
    expect_ptr("ptr_wrap", 8'h00);
    set_ptr(8'h05);
    exp_q.push_back({8'h05, 8'h22});
    host_write(1'b1, 8'h22, 8'h00);
    expect_ptr("ptr_low_hold", 8'h05);

    // Both strobes low: no access, bus not driven.
    set_ptr(8'h30);
    @(posedge clk); #1;
    a0 = 1'b1; host_oe = 1'b0; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); check("overlap_bus", 16'(bus), 16'h00FF);
    @(posedge clk); #1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(posedge clk);
    expect_ptr("overlap_ptr", 8'h30);

    // Reset in the middle of a data write drops it.
    set_ptr(8'h40);
    @(posedge clk); #1;
    a0 = 1'b1; host_d = 8'h77; host_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; cs_n = 1'b1; wr_n = 1'b1; host_oe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst2_intrq", 16'(intrq), 16'h0000);
    check("rst2_bus", 16'(bus), 16'h00FF);
    @(posedge clk); #1; rst = 1'b0;
    repeat (6) @(posedge clk);
    expect_ptr("rst2_ptr", 8'h00);
    peek("rst2_stat", 8'h0D, 8'h00);
    peek("rst2_en", 8'h06, 8'h00);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wr_queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
